// File: rtl/axi4_burst_master.sv
// AXI4 INCR burst initiator: one command at a time, W/R beats streamed to/from the user side.
// AW/AR one cycle after command capture; done one cycle after last B/R beat; AXI_MASTER stall watchdog under AXI4_MASTER_TIMEOUT_EN.
module axi4_burst_master #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [2:0]            cmd_size,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  done,
    output logic [1:0]            done_resp,
    output logic                  done_err,
    output logic                  err_timeout,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d, cnt_q, cnt_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            resp_q, resp_d;
    logic                  err_q, err_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  bready_q, bready_d;
    logic                  done_q, done_d;
    logic [15:0]           span;
    logic                  w_hs, r_hs, last_beat;

    assign w_hs      = (state_q == S_W) && wr_valid && WREADY;
    assign r_hs      = (state_q == S_R) && RVALID && rd_ready;
    assign last_beat = (cnt_q == len_q);
    // Offset of the final beat inside the 4KB page; anything past 0xFFF crosses it.
    assign span      = {4'd0, cmd_addr[11:0]} + ({8'd0, cmd_len} << cmd_size);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        resp_d  = resp_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr;
                    len_d  = cmd_len;
                    size_d = cmd_size;
                    cnt_d  = 8'd0;
                    resp_d = 2'b00;
                    err_d  = 1'b0;
                    if (span > 16'h0FFF) begin
                        state_d = S_DONE;
                        resp_d  = 2'b10;
                    end else begin
                        state_d = cmd_write ? S_AW : S_AR;
                    end
                end
            end
            S_AW: if (AWREADY) state_d = S_W;
            S_W: begin
                if (w_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (last_beat) state_d = S_B;
                end
            end
            S_B: begin
                if (BVALID) begin
                    if (BRESP > resp_q) resp_d = BRESP;
                    state_d = S_DONE;
                end
            end
            S_AR: if (ARREADY) state_d = S_R;
            S_R: begin
                if (r_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if (RRESP > resp_q) resp_d = RRESP;
                    if (RLAST != last_beat) err_d = 1'b1;
                    if (RLAST || last_beat) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cmd_ready_d = (state_d == S_IDLE);
        awvalid_d   = (state_d == S_AW);
        arvalid_d   = (state_d == S_AR);
        bready_d    = (state_d == S_B);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            cnt_q       <= 8'd0;
            resp_q      <= 2'b00;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            done_q      <= done_d;
        end
    end

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must fit the 16-bit stall counter");
    end

`ifdef AXI4_MASTER_TIMEOUT_EN
    logic [15:0] stall_q, stall_d;
    logic        tmo_q, tmo_d;
    logic        chan_hs, chan_wait;

    always_comb begin
        chan_wait = 1'b1;
        chan_hs   = 1'b0;
        unique case (state_q)
            S_AW:    chan_hs = AWREADY;
            S_W:     chan_hs = w_hs;
            S_B:     chan_hs = BVALID;
            S_AR:    chan_hs = ARREADY;
            S_R:     chan_hs = r_hs;
            default: chan_wait = 1'b0;
        endcase
        if (!chan_wait || chan_hs)  stall_d = 16'd0;
        else if (stall_q == 16'hFFFF) stall_d = stall_q;
        else                         stall_d = stall_q + 16'd1;
        tmo_d = tmo_q || (stall_d >= 16'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            stall_q <= 16'd0;
            tmo_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            tmo_q   <= tmo_d;
        end
    end

    assign err_timeout = tmo_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign cmd_ready = cmd_ready_q;
    assign AWADDR    = addr_q;
    assign AWLEN     = len_q;
    assign AWSIZE    = size_q;
    assign AWBURST   = 2'b01;
    assign AWVALID   = awvalid_q;
    assign WDATA     = wr_data;
    assign WLAST     = (state_q == S_W) && last_beat;
    assign WVALID    = (state_q == S_W) && wr_valid;
    assign wr_ready  = (state_q == S_W) && WREADY;
    assign BREADY    = bready_q;
    assign ARADDR    = addr_q;
    assign ARLEN     = len_q;
    assign ARSIZE    = size_q;
    assign ARBURST   = 2'b01;
    assign ARVALID   = arvalid_q;
    assign RREADY    = (state_q == S_R) && rd_ready;
    assign rd_valid  = (state_q == S_R) && RVALID;
    assign rd_data   = RDATA;
    assign rd_last   = RLAST;
    assign done      = done_q;
    assign done_resp = resp_q;
    assign done_err  = err_q;
endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: memory-backed AXI4 responder plus read/done scoreboards.
module tb_axi4_burst_master;
`ifdef AXI4_MASTER_TIMEOUT_EN
    localparam logic TMO_EXP = 1'b1;
`else
    localparam logic TMO_EXP = 1'b0;
`endif

    logic        ACLK, ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [2:0]  cmd_size;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done, done_err, err_timeout;
    logic [1:0]  done_resp;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [31:0] WDATA, RDATA;

    axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_resp(done_resp), .done_err(done_err), .err_timeout(err_timeout),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [1:0] resp;
        logic       err;
        bit         lat;
    } done_t;

    done_t       exp_done[$];
    logic [32:0] exp_rd[$];
    logic [31:0] wr_q[$];
    logic [31:0] exp_mem [1024];

    int b_delay    = 0;
    int rlast_mode = 0;
    bit rd_toggle  = 0;
    int aw_seen    = 0;
    int w_total    = 0;
    int fire_cyc   = 0;

    // Responder: 1024-word memory, SLVERR beyond it, configurable B delay and RLAST faults.
    initial begin : responder
        logic [31:0] resp_mem [1024];
        logic        s_rst, s_aw, s_w, s_b, s_ar, s_r, s_rlast, r_act, b_pend, w_err;
        logic [31:0] s_wdata;
        int          aw_addr, aw_size, ar_addr, ar_size, w_cnt, r_cnt, b_wait, idx;
        logic [7:0]  aw_len, ar_len;
        AWREADY = 1; WREADY = 1; ARREADY = 1;
        BVALID = 0; BRESP = 0; RVALID = 0; RDATA = 0; RRESP = 0; RLAST = 0;
        r_act = 0; b_pend = 0; w_err = 0; w_cnt = 0; r_cnt = 0; b_wait = 0;
        aw_addr = 0; aw_size = 0; ar_addr = 0; ar_size = 0; aw_len = 0; ar_len = 0;
        for (int i = 0; i < 1024; i++) resp_mem[i] = '0;
        forever begin
            @(negedge ACLK);
            s_rst = ARESET; s_aw = AWVALID && AWREADY; s_w = WVALID && WREADY;
            s_b = BVALID && BREADY; s_ar = ARVALID && ARREADY; s_r = RVALID && RREADY;
            s_rlast = RLAST; s_wdata = WDATA;
            if (AWVALID) aw_seen++;
            if (s_w) chk("wlast", WLAST, (w_cnt == int'(aw_len)));
            if (r_act) begin
                chk("rready_mirror", RREADY, rd_ready);
                chk("rd_valid_mirror", rd_valid, RVALID);
            end
            if (s_b || (s_r && (s_rlast || r_cnt == int'(ar_len)))) fire_cyc = cyc + 1;
            @(posedge ACLK); #1;
            if (s_rst) begin
                r_act = 0; b_pend = 0; BVALID = 0; w_cnt = 0; w_err = 0;
            end else begin
                if (s_aw) begin
                    aw_addr = int'(AWADDR); aw_len = AWLEN; aw_size = int'(AWSIZE);
                    w_cnt = 0; w_err = 0;
                end
                if (s_w) begin
                    idx = (aw_addr + (w_cnt << aw_size)) >> 2;
                    if (idx < 1024) resp_mem[idx] = s_wdata;
                    else w_err = 1;
                    w_total++;
                    if (w_cnt == int'(aw_len)) begin b_pend = 1; b_wait = b_delay; end
                    w_cnt++;
                end
                if (s_b) BVALID = 0;
                if (b_pend) begin
                    if (b_wait == 0) begin
                        BVALID = 1; BRESP = w_err ? 2'b10 : 2'b00; b_pend = 0;
                    end else b_wait--;
                end
                if (s_ar) begin
                    ar_addr = int'(ARADDR); ar_len = ARLEN; ar_size = int'(ARSIZE);
                    r_cnt = 0; r_act = 1;
                end else if (s_r) begin
                    if (s_rlast || r_cnt == int'(ar_len)) r_act = 0;
                    else r_cnt++;
                end
            end
            RVALID = r_act;
            RLAST  = 0;
            if (r_act) begin
                idx   = (ar_addr + (r_cnt << ar_size)) >> 2;
                RDATA = (idx < 1024) ? resp_mem[idx] : 32'h0;
                RRESP = (idx < 1024) ? 2'b00 : 2'b10;
                case (rlast_mode)
                    1:       RLAST = (r_cnt == 1);
                    2:       RLAST = 1'b0;
                    default: RLAST = (r_cnt == int'(ar_len));
                endcase
            end
        end
    end

    // User side: write-beat source from wr_q, read-beat sink checked against exp_rd.
    initial begin : user_side
        logic        s_rst, s_wf, s_rf;
        logic [32:0] e;
        wr_valid = 0; wr_data = 0; rd_ready = 1;
        forever begin
            @(negedge ACLK);
            s_rst = ARESET; s_wf = wr_valid && wr_ready; s_rf = rd_valid && rd_ready;
            if (s_rf) begin
                chk("rd_beat_expected", (exp_rd.size() > 0), 1'b1);
                if (exp_rd.size() > 0) begin
                    e = exp_rd.pop_front();
                    chk("rd_data", rd_data, e[31:0]);
                    chk("rd_last", rd_last, e[32]);
                end
            end
            @(posedge ACLK); #1;
            if (s_rst) wr_q.delete();
            else if (s_wf) void'(wr_q.pop_front());
            wr_valid = (wr_q.size() > 0);
            wr_data  = wr_valid ? wr_q[0] : 32'h0;
            rd_ready = rd_toggle ? ~rd_ready : 1'b1;
        end
    end

    task automatic do_cmd(input logic w, input logic [15:0] a, input logic [7:0] l, input logic [2:0] s);
        bit hs = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l; cmd_size = s;
        for (int i = 0; i < 50 && !hs; i++) begin
            @(negedge ACLK);
            hs = cmd_ready;
            @(posedge ACLK); #2;
        end
        cmd_valid = 0;
        chk("cmd_accept", hs, 1'b1);
    endtask

    task automatic wait_done(input int limit);
        bit    seen = 0;
        done_t e;
        for (int i = 0; i < limit && !seen; i++) begin
            if (done) seen = 1;
            else begin @(posedge ACLK); #2; end
        end
        chk("done_seen", seen, 1'b1);
        e = exp_done.pop_front();
        chk("done_resp", done_resp, e.resp);
        chk("done_err", done_err, e.err);
        if (e.lat) chk("done_latency", cyc, fire_cyc);
        @(posedge ACLK); #2;
        chk("done_one_cycle", done, 1'b0);
        chk("cmd_ready_after_done", cmd_ready, 1'b1);
    endtask

    task automatic wr_burst(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [31:0] base);
        int idx;
        for (int i = 0; i <= int'(l); i++) begin
            wr_q.push_back(base + 32'(i));
            idx = (int'(a) + (i << s)) >> 2;
            if (idx < 1024) exp_mem[idx] = base + 32'(i);
        end
        exp_done.push_back('{resp: 2'b00, err: 1'b0, lat: 1'b1});
        do_cmd(1'b1, a, l, s);
        chk("awvalid", AWVALID, 1'b1);
        chk("awaddr", AWADDR, a);
        chk("awlen", AWLEN, l);
        chk("awsize", AWSIZE, s);
        chk("awburst", AWBURST, 2'b01);
        chk("cmd_ready_busy", cmd_ready, 1'b0);
        wait_done(100);
    endtask

    task automatic rd_burst(input logic [15:0] a, input logic [7:0] l, input logic [2:0] s,
                            input int nbeats, input logic last_final,
                            input logic [1:0] eresp, input logic eerr);
        int          idx;
        logic [31:0] d;
        for (int i = 0; i < nbeats; i++) begin
            idx = (int'(a) + (i << s)) >> 2;
            d   = (idx < 1024) ? exp_mem[idx] : 32'h0;
            exp_rd.push_back({(i == nbeats - 1) ? last_final : 1'b0, d});
        end
        exp_done.push_back('{resp: eresp, err: eerr, lat: 1'b1});
        do_cmd(1'b0, a, l, s);
        chk("arvalid", ARVALID, 1'b1);
        chk("araddr", ARADDR, a);
        chk("arlen", ARLEN, l);
        chk("arsize", ARSIZE, s);
        chk("arburst", ARBURST, 2'b01);
        wait_done(400);
        chk("rd_all_delivered", exp_rd.size(), 0);
    endtask

    initial begin : main
        int base, aw_before;
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_size = 0;
        ARESET = 1;
        for (int i = 0; i < 1024; i++) exp_mem[i] = '0;
        repeat (3) @(posedge ACLK);
        #2;
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_awvalid", AWVALID, 1'b0);
        chk("rst_arvalid", ARVALID, 1'b0);
        chk("rst_wvalid", WVALID, 1'b0);
        chk("rst_bready", BREADY, 1'b0);
        chk("rst_rready", RREADY, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_done_resp", done_resp, 2'b00);
        chk("rst_done_err", done_err, 1'b0);
        chk("rst_err_timeout", err_timeout, 1'b0);
        chk("rst_awaddr", AWADDR, 16'h0);
        chk("rst_awlen", AWLEN, 8'h0);
        chk("rst_awsize", AWSIZE, 3'h0);
        ARESET = 0;
        @(posedge ACLK); #2;
        chk("cmd_ready_after_rst", cmd_ready, 1'b1);

        wr_burst(16'h0010, 8'd3, 3'd2, 32'hA0);
        rd_burst(16'h0010, 8'd3, 3'd2, 4, 1'b1, 2'b00, 1'b0);

        // 4KB crossing: no bus activity, done straight from capture with SLVERR-style response.
        aw_before = aw_seen;
        exp_done.push_back('{resp: 2'b10, err: 1'b0, lat: 1'b0});
        do_cmd(1'b1, 16'h0FFC, 8'd1, 3'd2);
        chk("x4k_no_awvalid", AWVALID, 1'b0);
        chk("x4k_done_now", done, 1'b1);
        wait_done(10);
        chk("x4k_aw_never", aw_seen - aw_before, 0);

        rd_burst(16'h1000, 8'd1, 3'd2, 2, 1'b1, 2'b10, 1'b0);

        wr_burst(16'h0040, 8'd7, 3'd2, 32'hB0);
        rd_toggle = 1;
        rd_burst(16'h0040, 8'd7, 3'd2, 8, 1'b1, 2'b00, 1'b0);
        rd_toggle = 0;

        rlast_mode = 1;
        rd_burst(16'h0010, 8'd3, 3'd2, 2, 1'b1, 2'b00, 1'b1);
        rlast_mode = 2;
        rd_burst(16'h0010, 8'd3, 3'd2, 4, 1'b0, 2'b00, 1'b1);
        rlast_mode = 0;

        rd_burst(16'h0000, 8'd255, 3'd2, 256, 1'b1, 2'b00, 1'b0);

        // Reset in the middle of a write burst.
        base = w_total;
        for (int i = 0; i < 4; i++) wr_q.push_back(32'hC0 + 32'(i));
        do_cmd(1'b1, 16'h0080, 8'd3, 3'd2);
        for (int i = 0; i < 50 && (w_total - base) < 2; i++) begin @(posedge ACLK); #2; end
        chk("midrst_beat2", w_total - base, 2);
        ARESET = 1;
        @(posedge ACLK); #2;
        chk("midrst_wvalid", WVALID, 1'b0);
        chk("midrst_awvalid", AWVALID, 1'b0);
        chk("midrst_cmd_ready", cmd_ready, 1'b0);
        chk("midrst_done", done, 1'b0);
        ARESET = 0;
        @(posedge ACLK); #2;
        chk("midrst_cmd_ready_next", cmd_ready, 1'b1);
        chk("midrst_wvalid_next", WVALID, 1'b0);

        // Stalled B channel: watchdog flag only when the feature is built in.
        chk("tmo_before", err_timeout, 1'b0);
        b_delay = 20;
        wr_burst(16'h0000, 8'd0, 3'd2, 32'h55);
        chk("tmo_after_done", err_timeout, TMO_EXP);
        b_delay = 0;
        rd_burst(16'h0000, 8'd0, 3'd2, 1, 1'b1, 2'b00, 1'b0);
        chk("tmo_sticky", err_timeout, TMO_EXP);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
